// File: rtl/branch_predictor.sv
// Branch direction/target predictor for the five-stage RV64 pipeline.
// Tagged direct-mapped table of saturating counters and targets, queried by
// fetch (0-cycle), trained by decode-resolved branches/jumps, with a
// sequenced table-flush FSM and wrapping performance counters.
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   lookup_*               fetch query -> pred_taken / pred_target (comb)
//   upd_*                  resolved branch/jump feedback
//   mispredict, redirect_pc  redirect request and correct next PC (comb)
//   flush_table, busy      start table invalidate / invalidate in progress
//   branch_cnt, miss_cnt   qualifying updates / mispredicts seen
module branch_predictor #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned TAG_W   = 10,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lookup_valid,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_is_branch,
    input  logic             upd_is_jump,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic             flush_table,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Table storage
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] jmp_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit, up_qual, idle;
    logic [CTR_W-1:0] ctr_cur, ctr_nxt;

    // Address bits outside index/tag are intentionally ignored
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], lookup_pc[XLEN-1:IDX_W+TAG_W+2],
                              upd_pc[1:0], upd_pc[XLEN-1:IDX_W+TAG_W+2]};

    assign idle   = (state_q == ST_IDLE);
    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Fetch-side lookup; lookups miss while the table is being cleared
    always_comb begin
        lk_hit      = lookup_valid & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag) & idle;
        pred_taken  = lk_hit & (jmp_q[lk_idx] | ctr_q[lk_idx][CTR_W-1]);
        pred_target = pred_taken ? tgt_q[lk_idx] : lookup_pc + XLEN'(4);
    end

    // Resolve-side check; a non-branch predicted taken is a table alias
    always_comb begin
        up_qual = upd_valid & (upd_is_branch | upd_is_jump);
        up_hit  = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
        if (up_qual) begin
            mispredict = (upd_taken != upd_pred_taken) |
                         (upd_taken & (upd_target != upd_pred_target));
        end else begin
            mispredict = upd_valid & upd_pred_taken;
        end
        redirect_pc = (up_qual & upd_taken) ? upd_target : upd_pc + XLEN'(4);
    end

    // Saturating counter step for the entry being trained
    always_comb begin
        ctr_cur = ctr_q[up_idx];
        ctr_nxt = ctr_cur;
        if (upd_taken) begin
            if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + CTR_W'(1);
        end else begin
            if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_W'(1);
        end
    end

    // Flush FSM next state and perf counter next values
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        branch_cnt_d = branch_cnt_q + CNT_W'(up_qual);
        miss_cnt_d   = miss_cnt_q + CNT_W'(mispredict);
        case (state_q)
            ST_IDLE: begin
                if (flush_table) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (flush_table) begin
                    ptr_d = '0;
                end else if (ptr_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Table writes: clear sweep while flushing, otherwise training
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            jmp_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= CTR_WNT;
                tgt_q[i] <= '0;
            end
        end else if (!idle) begin
            valid_q[ptr_q] <= 1'b0;
            ctr_q[ptr_q]   <= CTR_WNT;
        end else if (up_qual) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_nxt;
                jmp_q[up_idx] <= upd_is_jump;
                if (upd_taken) tgt_q[up_idx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                tgt_q[up_idx]   <= upd_target;
                jmp_q[up_idx]   <= upd_is_jump;
                ctr_q[up_idx]   <= CTR_WT;
            end
        end else if (upd_valid && up_hit) begin
            valid_q[up_idx] <= 1'b0;
        end
    end

    assign busy       = ~idle;
    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule
